// File: rtl/oled_spi_receiver.sv
// oled_spi_receiver: Pmod OLED SPI slave rebuilding the command/data byte stream into a show-ahead FIFO.
module oled_spi_receiver #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs,
  input  logic       dc,
  input  logic       res,
  input  logic       rd_en,
  input  logic       clr,
  output logic [7:0] byte_out,
  output logic       byte_dc,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       frag_err,
  output logic       disp_on,
  output logic [7:0] cmd_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, SHIFT} state_e;
  logic [4:0] sync_q [SYNC_STAGES];
  logic sclk_s, mosi_s, cs_s, dc_s, res_s;
  logic sclk_dly_q, cs_dly_q;
  state_e state_q;
  logic [2:0] cnt_q;
  logic [7:0] shift_q, byte_in, cmd_q;
  logic frag_q, ovf_q, disp_q;
  logic rise, shifting, done, frag_set, pop, wr_ok;
  logic [AW:0] wr_q, rd_q;
  logic [8:0] mem_q [FIFO_DEPTH];
  // cs and res synchronize to their inactive (high) levels so reset release looks idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 5'b00101;
    end else begin
      sync_q[0] <= {sclk, mosi, cs, dc, res};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign {sclk_s, mosi_s, cs_s, dc_s, res_s} = sync_q[SYNC_STAGES-1];
  assign rise     = sclk_s & ~sclk_dly_q;
  assign shifting = (state_q == SHIFT) & ~cs_s & res_s;
  assign done     = shifting & rise & (cnt_q == 3'd7);
  assign byte_in  = {shift_q[6:0], mosi_s};
  assign frag_set = (state_q == SHIFT) & cs_s & res_s & (cnt_q != 3'd0);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_dly_q <= 1'b0;
      cs_dly_q   <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 8'd0;
      frag_q     <= 1'b0;
      disp_q     <= 1'b0;
      cmd_q      <= 8'd0;
    end else begin
      sclk_dly_q <= sclk_s;
      cs_dly_q   <= cs_s;
      state_q    <= cs_s ? IDLE : ((state_q == IDLE && cs_dly_q) ? SHIFT : state_q);
      frag_q     <= (frag_q & ~clr) | frag_set;
      if (!res_s || cs_s) begin
        cnt_q   <= 3'd0;
        shift_q <= 8'd0;
      end else if (shifting && rise) begin
        cnt_q   <= cnt_q + 3'd1;
        shift_q <= byte_in;
      end
      if (!res_s) disp_q <= 1'b0;
      else if (done && !dc_s && byte_in == 8'hAF) disp_q <= 1'b1;
      else if (done && !dc_s && byte_in == 8'hAE) disp_q <= 1'b0;
      if (done && !dc_s) cmd_q <= cmd_q + 8'd1;
    end
  end
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = rd_en & ~empty;
  assign wr_ok = done & (~full | pop);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~clr) | (done & full & ~pop);
      if (!res_s) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (wr_ok) wr_q <= wr_q + 1'b1;
        if (pop) rd_q <= rd_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_q[AW-1:0]] <= {dc_s, byte_in};
  end
  assign {byte_dc, byte_out} = empty ? 9'd0 : mem_q[rd_q[AW-1:0]];
  assign overflow  = ovf_q;
  assign frag_err  = frag_q;
  assign disp_on   = disp_q;
  assign cmd_count = cmd_q;
endmodule
